// File: rtl/mux32_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux32_rr_arbiter
//   Two-requester round-robin multiplexer feeding a single registered output
//   slot. A word is accepted whenever the output slot is empty or is being
//   drained in the same cycle, so a continuously ready consumer sees one word
//   per clock with no bubble. When both requesters are active, the one that was
//   not granted most recently wins.
//
// Ports
//   clk      : system clock, rising-edge active
//   clrn     : asynchronous active-low reset
//   req0/1   : requester N holds a valid word
//   a0/a1    : requester N data (WIDTH bits)
//   ack0/1   : requester N word accepted this cycle (combinational)
//   y_valid  : output slot holds a word
//   y        : registered output word
//   y_src    : index of the requester that supplied y
//   y_ready  : consumer takes y this cycle when y_valid=1
//   cnt0/1   : saturating (255) count of words accepted per requester
// -----------------------------------------------------------------------------
module mux32_rr_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    output logic             ack1,
    output logic             y_valid,
    output logic [WIDTH-1:0] y,
    output logic             y_src,
    input  logic             y_ready,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t state_r;
    logic   last_grant_r;
    logic   accept_s;
    logic   grant0_s;
    logic   grant1_s;
    logic   ack0_s;
    logic   ack1_s;

    // Counter increment that sticks at the top value instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    // Slot can take a new word when empty, or when full and being drained now.
    assign accept_s = (state_r == ST_EMPTY) | y_ready;

    // Round-robin selection: on contention, favour the requester not granted last.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (req0 && req1) begin
            if (last_grant_r) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
        end else if (req0) begin
            grant0_s = 1'b1;
        end else if (req1) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Acks are gated by clrn so that nothing is handshaken while held in reset.
    assign ack0_s = clrn & accept_s & grant0_s;
    assign ack1_s = clrn & accept_s & grant1_s;
    assign ack0   = ack0_s;
    assign ack1   = ack1_s;

    assign y_valid = (state_r == ST_FULL);

    // Output FSM with the data slot, source tag, round-robin pointer and counters.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r      <= ST_EMPTY;
            y            <= '0;
            y_src        <= 1'b0;
            last_grant_r <= 1'b1;   // makes requester 0 win the first contention
            cnt0         <= 8'd0;
            cnt1         <= 8'd0;
        end else begin
            case (state_r)
                ST_EMPTY, ST_FULL: begin
                    if (accept_s) begin
                        if (ack0_s) begin
                            y            <= a0;
                            y_src        <= 1'b0;
                            last_grant_r <= 1'b0;
                            state_r      <= ST_FULL;
                            cnt0         <= sat_inc(cnt0);
                        end else if (ack1_s) begin
                            y            <= a1;
                            y_src        <= 1'b1;
                            last_grant_r <= 1'b1;
                            state_r      <= ST_FULL;
                            cnt1         <= sat_inc(cnt1);
                        end else begin
                            // Slot drained (or stayed empty) with nothing to refill it.
                            state_r <= ST_EMPTY;
                        end
                    end else begin
                        state_r <= state_r;   // stalled: hold word and tag
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule
